// File: rtl/sync_bus_pkg.sv
// Shared types and defaults for the synchronous 8-bit address/data bus.
// Used by the bus master and the device-side blocks.
package sync_bus_pkg;

  localparam int ADDR_W_DEF    = 8;
  localparam int DATA_W_DEF    = 8;
  localparam int BUS_IDLE_ADDR = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Width of a counter that must reach max_cnt without wrapping.
  function automatic int cnt_width(input int max_cnt);
    return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/sync_bus_master_if.sv
// Request/response handshake plus device-side bus signals of the bus master.
// master: the initiator's view; slave: the requester and device view.
interface sync_bus_master_if
  import sync_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rd;
  logic              bus_wr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, bus_rdata, bus_ack,
    output req_ready, resp_valid, resp_data, resp_err,
           bus_addr, bus_rd, bus_wr, bus_wdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, bus_rdata, bus_ack,
    input  req_ready, resp_valid, resp_data, resp_err,
           bus_addr, bus_rd, bus_wr, bus_wdata
  );

endinterface

// File: rtl/bus_wait_timer.sv
// Loadable wait counter: saturates at TIMEOUT-1 and flags it; clear beats load beats enable.
// Zero latency on the flag; no backpressure.
module bus_wait_timer
  import sync_bus_pkg::*;
#(
  parameter int TIMEOUT = 4,
  parameter int CNT_W   = cnt_width(TIMEOUT)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_term
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_term;

  assign w_term = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign o_term = w_term;

  // Holding at the terminal value keeps the count from ever wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && !w_term) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sync_bus_master.sv
// Bus initiator: one request at a time, strobes held until ack or TIMEOUT, one-cycle response.
// Ack in first BUSY cycle gives resp two cycles after accept; req_ready low in BUSY and RESP.
module sync_bus_master
  import sync_bus_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 4
) (
  input  logic           clock,
  input  logic           reset,
  sync_bus_master_if.master bus
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  state_e            r_state;
  state_e            w_next;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_err;

  logic              w_latch;
  logic              w_tmr_clr;
  logic              w_tmr_en;
  logic              w_tmr_term;
  logic              w_resp_ld;
  logic              w_resp_err;
  logic [DATA_W-1:0] w_resp_data;
  logic              w_busy;

  bus_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .i_clr      (w_tmr_clr),
    .i_en       (w_tmr_en),
    .i_load     (1'b0),
    .i_load_val ({CNT_W{1'b0}}),
    .o_term     (w_tmr_term)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_latch     = 1'b0;
    w_tmr_clr   = 1'b0;
    w_tmr_en    = 1'b0;
    w_resp_ld   = 1'b0;
    w_resp_err  = 1'b0;
    w_resp_data = '0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_latch   = 1'b1;
          w_tmr_clr = 1'b1;
          w_next    = BUSY;
        end
      end
      BUSY: begin
        // Ack takes priority over an expiring wait on the same edge.
        if (bus.bus_ack) begin
          w_resp_ld   = 1'b1;
          w_resp_data = r_write ? '0 : bus.bus_rdata;
          w_next      = RESP;
        end else if (w_tmr_term) begin
          w_resp_ld  = 1'b1;
          w_resp_err = 1'b1;
          w_next     = RESP;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      if (w_latch) begin
        r_write <= bus.req_write;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
      if (w_resp_ld) begin
        r_resp_data <= w_resp_data;
        r_resp_err  <= w_resp_err;
      end
    end
  end

  assign w_busy = (r_state == BUSY);

  // Gate req_ready with reset so nothing looks acceptable while reset is held.
  assign bus.req_ready  = (r_state == IDLE) && !reset;
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_err   = r_resp_err;
  assign bus.bus_addr   = w_busy ? r_addr : ADDR_W'(BUS_IDLE_ADDR);
  assign bus.bus_rd     = w_busy && !r_write;
  assign bus.bus_wr     = w_busy && r_write;
  assign bus.bus_wdata  = (w_busy && r_write) ? r_wdata : '0;

endmodule

// File: tb/tb_sync_bus_master.sv
// Directed per-cycle vectors for sync_bus_master, plus sequences for reset abort and TIMEOUT=1.
module tb_sync_bus_master;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clock = ~clock;

  sync_bus_master_if #(.ADDR_W(8), .DATA_W(8)) b0 ();
  sync_bus_master_if #(.ADDR_W(8), .DATA_W(8)) b1 ();

  sync_bus_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (b0.master)
  );

  sync_bus_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (b1.master)
  );

  typedef struct {
    logic       rst, vld, wr;
    logic [7:0] addr, wdata, rdata;
    logic       ack;
    logic       e_rdy, e_rd, e_wr;
    logic [7:0] e_addr, e_wdata;
    logic       e_rv;
    logic [7:0] e_rdat;
    logic       e_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, vld, wr, input logic [7:0] addr, wdata, rdata,
                     input logic ack, e_rdy, e_rd, e_wr, input logic [7:0] e_addr, e_wdata,
                     input logic e_rv, input logic [7:0] e_rdat, input logic e_err);
    vec_t v;
    v = '{rst, vld, wr, addr, wdata, rdata, ack,
          e_rdy, e_rd, e_wr, e_addr, e_wdata, e_rv, e_rdat, e_err};
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs0();
    b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_addr = 8'h00;
    b0.req_wdata = 8'h00; b0.bus_rdata = 8'h00; b0.bus_ack = 1'b0;
  endtask

  task automatic idle_inputs1();
    b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_addr = 8'h00;
    b1.req_wdata = 8'h00; b1.bus_rdata = 8'h00; b1.bus_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs0();
    idle_inputs1();

    //   rst vld wr addr   wdata  rdata  ack | rdy rd wr baddr  bwdata rv rdat   err
    add(1, 0, 0, 8'h00, 8'h00, 8'h00, 0,  0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);  // c0
    add(1, 0, 0, 8'h00, 8'h00, 8'h00, 0,  0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    add(1, 0, 0, 8'h00, 8'h00, 8'h00, 0,  0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 8'h00, 8'h00, 0,  1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);  // c3 released
    add(0, 1, 0, 8'hF0, 8'h00, 8'h00, 0,  1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);  // read F0
    add(0, 0, 0, 8'h00, 8'h00, 8'hE3, 1,  0, 1, 0, 8'hF0, 8'h00, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 8'h00, 8'h11, 1,  0, 0, 0, 8'h00, 8'h00, 1, 8'hE3, 0);  // ack in RESP ignored
    add(0, 1, 1, 8'h10, 8'h5A, 8'h22, 1,  1, 0, 0, 8'h00, 8'h00, 0, 8'hE3, 0);  // write 5A->10
    add(0, 0, 0, 8'h00, 8'h00, 8'h77, 0,  0, 0, 1, 8'h10, 8'h5A, 0, 8'hE3, 0);
    add(0, 0, 0, 8'h00, 8'h00, 8'h77, 0,  0, 0, 1, 8'h10, 8'h5A, 0, 8'hE3, 0);
    add(0, 0, 0, 8'h00, 8'h00, 8'h77, 1,  0, 0, 1, 8'h10, 8'h5A, 0, 8'hE3, 0);
    add(0, 0, 0, 8'h00, 8'h00, 8'h00, 0,  0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 0);
    add(0, 1, 0, 8'h33, 8'hA5, 8'h00, 0,  1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);  // read 33, no device
    for (int k = 0; k < 4; k++)
      add(0, 0, 0, 8'h00, 8'h00, 8'h00, 0,  0, 1, 0, 8'h33, 8'h00, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 8'h00, 8'h00, 0,  0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 1);  // timeout resp
    add(0, 1, 0, 8'h44, 8'h00, 8'h00, 0,  1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1);  // back-to-back
    add(0, 1, 0, 8'h44, 8'h00, 8'h9C, 1,  0, 1, 0, 8'h44, 8'h00, 0, 8'h00, 1);
    add(0, 1, 0, 8'h44, 8'h00, 8'h00, 0,  0, 0, 0, 8'h00, 8'h00, 1, 8'h9C, 0);
    add(0, 1, 0, 8'h44, 8'h00, 8'h00, 0,  1, 0, 0, 8'h00, 8'h00, 0, 8'h9C, 0);
    for (int k = 0; k < 3; k++)
      add(0, 1, 0, 8'h44, 8'h00, 8'h00, 0,  0, 1, 0, 8'h44, 8'h00, 0, 8'h9C, 0);
    add(0, 1, 0, 8'h44, 8'h00, 8'h3C, 1,  0, 1, 0, 8'h44, 8'h00, 0, 8'h9C, 0);  // ack on timeout edge
    add(0, 0, 0, 8'h00, 8'h00, 8'h00, 0,  0, 0, 0, 8'h00, 8'h00, 1, 8'h3C, 0);
    add(0, 0, 0, 8'h00, 8'h00, 8'h00, 0,  1, 0, 0, 8'h00, 8'h00, 0, 8'h3C, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clock);
      reset        = vq[i].rst;
      b0.req_valid = vq[i].vld;
      b0.req_write = vq[i].wr;
      b0.req_addr  = vq[i].addr;
      b0.req_wdata = vq[i].wdata;
      b0.bus_rdata = vq[i].rdata;
      b0.bus_ack   = vq[i].ack;
      #1;
      if (i != 0) begin
        check($sformatf("c%0d req_ready", i),  {7'd0, b0.req_ready},  {7'd0, vq[i].e_rdy});
        check($sformatf("c%0d bus_rd", i),     {7'd0, b0.bus_rd},     {7'd0, vq[i].e_rd});
        check($sformatf("c%0d bus_wr", i),     {7'd0, b0.bus_wr},     {7'd0, vq[i].e_wr});
        check($sformatf("c%0d bus_addr", i),   b0.bus_addr,           vq[i].e_addr);
        check($sformatf("c%0d bus_wdata", i),  b0.bus_wdata,          vq[i].e_wdata);
        check($sformatf("c%0d resp_valid", i), {7'd0, b0.resp_valid}, {7'd0, vq[i].e_rv});
        check($sformatf("c%0d resp_data", i),  b0.resp_data,          vq[i].e_rdat);
        check($sformatf("c%0d resp_err", i),   {7'd0, b0.resp_err},   {7'd0, vq[i].e_err});
      end
    end

    // Reset in the second BUSY cycle aborts the read without a response.
    @(negedge clock);
    b0.req_valid = 1'b1; b0.req_addr = 8'hF0; b0.req_write = 1'b0;
    #1 check("abort accept ready", {7'd0, b0.req_ready}, 8'd1);
    @(negedge clock);
    idle_inputs0();
    #1 check("abort busy1 rd", {7'd0, b0.bus_rd}, 8'd1);
    @(negedge clock);
    reset = 1'b1;
    #1 check("abort busy2 rd", {7'd0, b0.bus_rd}, 8'd1);
    check("abort busy2 ready", {7'd0, b0.req_ready}, 8'd0);
    @(negedge clock);
    reset = 1'b0;
    #1 check("abort rd dropped", {7'd0, b0.bus_rd}, 8'd0);
    check("abort addr cleared", b0.bus_addr, 8'h00);
    check("abort resp_data cleared", b0.resp_data, 8'h00);
    check("abort ready", {7'd0, b0.req_ready}, 8'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      #1 check($sformatf("abort no resp %0d", k), {7'd0, b0.resp_valid}, 8'd0);
    end
    @(negedge clock);
    b0.req_valid = 1'b1; b0.req_addr = 8'hF0;
    @(negedge clock);
    b0.req_valid = 1'b0; b0.req_addr = 8'h00; b0.bus_ack = 1'b1; b0.bus_rdata = 8'hE3;
    #1 check("reread rd", {7'd0, b0.bus_rd}, 8'd1);
    check("reread addr", b0.bus_addr, 8'hF0);
    @(negedge clock);
    idle_inputs0();
    #1 check("reread resp_valid", {7'd0, b0.resp_valid}, 8'd1);
    check("reread resp_data", b0.resp_data, 8'hE3);
    check("reread resp_err", {7'd0, b0.resp_err}, 8'd0);

    // TIMEOUT=1: a single BUSY cycle, then timeout or ack.
    @(negedge clock);
    b1.req_valid = 1'b1; b1.req_addr = 8'h55;
    #1 check("t1 ready", {7'd0, b1.req_ready}, 8'd1);
    @(negedge clock);
    idle_inputs1();
    #1 check("t1 busy rd", {7'd0, b1.bus_rd}, 8'd1);
    check("t1 busy addr", b1.bus_addr, 8'h55);
    @(negedge clock);
    #1 check("t1 timeout valid", {7'd0, b1.resp_valid}, 8'd1);
    check("t1 timeout err", {7'd0, b1.resp_err}, 8'd1);
    check("t1 timeout data", b1.resp_data, 8'h00);
    check("t1 rd dropped", {7'd0, b1.bus_rd}, 8'd0);
    @(negedge clock);
    b1.req_valid = 1'b1; b1.req_addr = 8'h66;
    #1 check("t1 idle ready", {7'd0, b1.req_ready}, 8'd1);
    @(negedge clock);
    idle_inputs1();
    b1.bus_ack = 1'b1; b1.bus_rdata = 8'hB7;
    #1 check("t1 ack busy rd", {7'd0, b1.bus_rd}, 8'd1);
    @(negedge clock);
    idle_inputs1();
    #1 check("t1 ack valid", {7'd0, b1.resp_valid}, 8'd1);
    check("t1 ack data", b1.resp_data, 8'hB7);
    check("t1 ack err", {7'd0, b1.resp_err}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_bus_master.md
Name: sync_bus_master

Overview:
- Initiator end of the team's synchronous 8-bit address/data bus.
- Accepts one read or write request at a time from a local requester and drives address plus strobe onto the bus.
- Waits for a device acknowledge or a timeout, then returns a one-cycle response.
- Sits between the CPU-side request logic and the shared device bus. Devices decode the address and answer on bus_rdata/bus_ack.

Parameters:
- ADDR_W, 8, bus address width.
- DATA_W, 8, bus data width.
- TIMEOUT, 4, maximum bus cycles to wait for bus_ack before an error response (legal range 1..255).

Ports:
- clock  input  1  single system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  requester has a transaction.
- req_ready  output  1  master can accept a request.
- req_write  input  1  1=write, 0=read.
- req_addr  input  ADDR_W  target address.
- req_wdata  input  DATA_W  write data.
- resp_valid  output  1  one-cycle response pulse.
- resp_data  output  DATA_W  read data; 0 for writes and errors.
- resp_err  output  1  1 = timeout (no device acknowledged).
- bus_addr  output  ADDR_W  address driven to devices.
- bus_rd  output  1  read strobe.
- bus_wr  output  1  write strobe.
- bus_wdata  output  DATA_W  write data to devices.
- bus_rdata  input  DATA_W  data returned by the addressed device.
- bus_ack  input  1  device acknowledge, sampled only in BUSY.

Behaviour:
Reset:
- Clock and reset: one clock; reset is synchronous and active-high.
- reset high at a rising edge: state=IDLE, wait counter=0, all outputs 0 (req_ready reads 1 once in IDLE after reset releases).
- Reset mid-transaction aborts it: strobes drop at the next edge and no response is issued.

States:
- IDLE: req_ready=1; bus outputs all 0.
  - On an edge with req_valid=1, latch write/addr/wdata, clear the counter, go to BUSY.
- BUSY: req_ready=0.
  - Drive bus_addr=latched addr and bus_wdata=latched wdata (write) or 0 (read).
  - Drive bus_rd=!write and bus_wr=write; exactly one strobe is high.
  - Strobes stay stable for the whole state.
  - At each edge:
    - bus_ack=1: capture bus_rdata (read) or 0 (write) into resp_data, resp_err=0, go to RESP.
    - else if counter==TIMEOUT-1: resp_data=0, resp_err=1, go to RESP.
    - else counter+1.
- RESP: resp_valid=1 for exactly one cycle; bus outputs 0; req_ready=0; next edge goes to IDLE.
  - resp_data and resp_err hold their values until the next response.

Latency and throughput:
- Request accepted at edge N; BUSY covers cycle N+1.
- Ack in the first BUSY cycle puts resp_valid high in cycle N+2.
- Timeout puts resp_valid high in cycle N+1+TIMEOUT.
- Minimum spacing between accepted requests is 3 cycles. No request is accepted while in RESP.

Boundary conditions:
- bus_ack outside BUSY is ignored.
- bus_ack and counter==TIMEOUT-1 on the same edge: ack wins, resp_err=0.
- TIMEOUT=1: a single BUSY cycle.
- The counter is sized ceil(log2(TIMEOUT+1)) bits and never wraps.
- req_valid dropping after acceptance has no effect.

Decomposition:
- Package sync_bus_pkg holds:
  - state enum {IDLE, BUSY, RESP};
  - ADDR_W/DATA_W defaults;
  - BUS_IDLE_ADDR=0.
  The device-side blocks share this package.
- Sub-module bus_wait_timer: a loadable up-counter with clear/enable and a terminal flag at TIMEOUT-1, reused by device-side wait logic.
- The FSM, latches and output muxing stay in sync_bus_master.

Test Plan:
1. Reset held 3 cycles, then released -> all outputs 0 during reset; req_ready=1 the cycle after release.
2. Read addr 0xF0; device model acks in the same cycle with rdata 0xE3 -> bus_rd=1 and bus_addr=0xF0 for 1 cycle; resp_valid in cycle N+2 with resp_data=0xE3, resp_err=0.
3. Write 0x5A to 0x10; device acks after 2 BUSY cycles -> bus_wr=1 and bus_wdata=0x5A for 3 cycles; resp_data=0, resp_err=0.
4. Read 0x33 with no device responding, TIMEOUT=4 -> bus_rd high exactly 4 cycles; resp_valid in cycle N+5 with resp_err=1, resp_data=0.
5. Back-to-back req_valid held high -> accepts at N and N+3 only; req_ready=0 during BUSY/RESP; ack on the timeout edge yields resp_err=0.
6. Reset asserted in the second BUSY cycle -> strobes 0 at the next edge; no resp_valid; a following read of 0xF0 completes normally with 0xE3.
